axis_mash11_dsm: RTL and testbench

//  MASH 1-1 (2nd-order, two cascaded 1st-order) delta-sigma modulator; downstream

---
 rtl/axis_mash11_dsm.sv | 122 ++++++++++++
 tb/tb_axis_mash11_dsm.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_mash11_dsm.sv
// MASH 1-1 delta-sigma modulator: holds each AXI-Stream sample for OSR ticks and
// drives a 4-level code plus thermometer bits for a 3-element unit DAC.
module axis_mash11_dsm #(
    parameter int DATA_WIDTH = 16,
    parameter int OSR        = 16
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    output logic [1:0]            dac_code,
    output logic [2:0]            dac_therm,
    output logic                  underrun,
    input  logic                  clear_underrun
);
    localparam int              CNT_W    = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic                    arst_q;
    logic                    nxt_vld;
    logic [DATA_WIDTH-1:0]   x;
    logic [DATA_WIDTH-1:0]   nxt;
    logic [DATA_WIDTH-1:0]   acc1;
    logic [DATA_WIDTH-1:0]   acc2;
    logic [CNT_W-1:0]        cnt;
    logic                    c2_d;

    logic [DATA_WIDTH:0]     s1;
    logic [DATA_WIDTH:0]     s2;
    logic signed [2:0]       y;
    logic [1:0]              code_next;
    logic                    hs;
    logic                    boundary;

    // y is in -1..2, so the offset code always fits in two bits
    function automatic logic [1:0] code_of(input logic signed [2:0] yv);
        logic signed [2:0] t;
        t = yv + 3'sd1;
        return t[1:0];
    endfunction

    function automatic logic [2:0] therm_of(input logic [1:0] c);
        logic [2:0] t;
        case (c)
            2'd0:    t = 3'b000;
            2'd1:    t = 3'b001;
            2'd2:    t = 3'b011;
            default: t = 3'b111;
        endcase
        return t;
    endfunction

    // Stage 1 feeds stage 2 with its wrapped sum; stage 2 carry is differentiated
    always_comb begin
        s1        = {1'b0, acc1} + {1'b0, x};
        s2        = {1'b0, acc2} + {1'b0, s1[DATA_WIDTH-1:0]};
        y         = signed'({2'b00, s1[DATA_WIDTH]}) + signed'({2'b00, s2[DATA_WIDTH]})
                    - signed'({2'b00, c2_d});
        code_next = code_of(y);
    end

    assign s_axis_data_tready = ~arst_q & ~nxt_vld;
    assign hs                 = s_axis_data_tvalid & s_axis_data_tready;
    assign boundary           = (cnt == CNT_LAST);

    always_ff @(posedge aclk) begin
        if (arst) begin
            state     <= IDLE;
            arst_q    <= 1'b1;
            acc1      <= '0;
            acc2      <= '0;
            c2_d      <= 1'b0;
            cnt       <= '0;
            x         <= '0;
            nxt_vld   <= 1'b0;
            dac_code  <= 2'd1;
            dac_therm <= 3'b001;
            underrun  <= 1'b0;
        end else begin
            arst_q <= 1'b0;
            if (clear_underrun)
                underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        x     <= s_axis_data_tdata;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc1      <= s1[DATA_WIDTH-1:0];
                    acc2      <= s2[DATA_WIDTH-1:0];
                    c2_d      <= s2[DATA_WIDTH];
                    dac_code  <= code_next;
                    dac_therm <= therm_of(code_next);
                    if (boundary) begin
                        cnt <= '0;
                        if (nxt_vld) begin
                            x       <= nxt;
                            nxt_vld <= 1'b0;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    // tready is low while nxt is full, so this never collides with a consume
                    if (hs) begin
                        nxt     <= s_axis_data_tdata;
                        nxt_vld <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_mash11_dsm.sv
// Bench for axis_mash11_dsm: cycle model feeds an expectation queue that is
// compared against the DUT on every falling edge, plus directed window checks.
module tb_axis_mash11_dsm;
    localparam int W   = 16;
    localparam int OSR = 16;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic [15:0] tdata = 16'h0;
    logic        tvalid = 1'b0;
    logic        clear = 1'b0;
    logic        tready;
    logic [1:0]  code;
    logic [2:0]  therm;
    logic        und;

    always #5 aclk = ~aclk;

    axis_mash11_dsm #(.DATA_WIDTH(W), .OSR(OSR)) dut (
        .aclk               (aclk),
        .arst               (arst),
        .s_axis_data_tdata  (tdata),
        .s_axis_data_tvalid (tvalid),
        .s_axis_data_tready (tready),
        .dac_code           (code),
        .dac_therm          (therm),
        .underrun           (und),
        .clear_underrun     (clear)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int code;
        bit und;
        bit rdy;
    } exp_t;
    exp_t q[$];
    exp_t e;

    // Behavioural model, written with integer arithmetic
    bit m_sb_on = 0, m_run = 0, m_nxt_vld = 0, m_arst_q = 0, m_und = 0;
    int m_acc1 = 0, m_acc2 = 0, m_c2d = 0, m_cnt = 0, m_x = 0, m_nxt = 0, m_code = 1;

    always @(posedge aclk) begin
        int s1, s2, c1, c2, y;
        bit hs, ev;
        hs = tvalid && !m_arst_q && !m_nxt_vld;
        ev = 0;
        if (arst) begin
            m_sb_on = 1; m_run = 0; m_nxt_vld = 0; m_arst_q = 1; m_und = 0;
            m_acc1 = 0; m_acc2 = 0; m_c2d = 0; m_cnt = 0; m_x = 0; m_code = 1;
        end else begin
            m_arst_q = 0;
            if (!m_run) begin
                if (hs) begin
                    m_x = int'(tdata); m_cnt = 0; m_run = 1;
                end
            end else begin
                s1 = m_acc1 + m_x;
                c1 = (s1 >= 65536) ? 1 : 0;
                m_acc1 = s1 % 65536;
                s2 = m_acc2 + m_acc1;
                c2 = (s2 >= 65536) ? 1 : 0;
                m_acc2 = s2 % 65536;
                y = c1 + c2 - m_c2d;
                m_c2d = c2;
                m_code = y + 1;
                if (m_cnt == OSR - 1) begin
                    m_cnt = 0;
                    if (m_nxt_vld) begin
                        m_x = m_nxt; m_nxt_vld = 0;
                    end else begin
                        ev = 1;
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                end
                if (hs) begin
                    m_nxt = int'(tdata); m_nxt_vld = 1;
                end
            end
            if (clear) m_und = 0;
            if (ev) m_und = 1;
        end
        if (m_sb_on) q.push_back('{m_code, m_und, !m_arst_q && !m_nxt_vld});
    end

    always @(negedge aclk) begin
        if (m_sb_on) begin
            if (q.size() == 0) begin
                check("sb_empty", 0, 1);
            end else begin
                e = q.pop_front();
                check("sb_code", code, e.code);
                check("sb_therm", therm, (1 << e.code) - 1);
                check("sb_underrun", und, e.und);
                check("sb_tready", tready, e.rdy);
            end
        end
    end

    task automatic do_reset(input int n);
        arst = 1'b1; tvalid = 1'b0; clear = 1'b0;
        repeat (n) @(negedge aclk);
        arst = 1'b0;
        @(negedge aclk);
    endtask

    // Returns just after the edge on which the pending handshake is taken
    task automatic wait_hs(input string tag);
        int k = 0;
        while (!(tvalid && tready) && k < 100) begin
            @(negedge aclk);
            k++;
        end
        check({tag, "_hs_timeout"}, (k < 100) ? 1 : 0, 1);
        @(negedge aclk);
    endtask

    initial begin
        int ysum, nhs;

        // Reset values and tready release
        repeat (3) @(negedge aclk);
        check("rst_code", code, 1);
        check("rst_therm", therm, 3'b001);
        check("rst_underrun", und, 0);
        check("rst_tready", tready, 0);
        arst = 1'b0;
        @(negedge aclk);
        check("rel_tready", tready, 1);

        // Zero input: code stays at 1
        tdata = 16'h0000; tvalid = 1'b1;
        wait_hs("zero");
        repeat (40) @(negedge aclk);
        check("zero_code", code, 1);
        check("zero_underrun", und, 0);

        // Half scale: y averages 1/2, one handshake per period
        do_reset(2);
        tdata = 16'h8000; tvalid = 1'b1;
        wait_hs("half");
        ysum = 0; nhs = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge aclk);
            ysum += int'(code) - 1;
            if (tvalid && tready) nhs++;
        end
        check("half_ysum", ysum, 32);
        check("half_handshakes", nhs, 4);
        check("half_underrun", und, 0);

        // Full scale over 2^16 ticks
        do_reset(2);
        tdata = 16'hFFFF; tvalid = 1'b1;
        wait_hs("full");
        ysum = 0;
        for (int i = 0; i < 65536; i++) begin
            @(negedge aclk);
            ysum += int'(code) - 1;
        end
        check("full_ysum_in_tol", (ysum >= 65534 && ysum <= 65536) ? 1 : 0, 1);

        // Underrun: single sample, then starve
        do_reset(2);
        tdata = 16'h3000; tvalid = 1'b1;
        wait_hs("urun");
        tvalid = 1'b0;
        repeat (15) @(negedge aclk);
        check("urun_before", und, 0);
        @(negedge aclk);
        check("urun_set", und, 1);
        clear = 1'b1;
        @(negedge aclk);
        clear = 1'b0;
        check("urun_cleared", und, 0);
        for (int k = 0; k < 40 && m_cnt != OSR - 1; k++) @(negedge aclk);
        check("urun_cnt_reached", m_cnt, OSR - 1);
        clear = 1'b1;
        @(negedge aclk);
        clear = 1'b0;
        check("urun_set_wins", und, 1);

        // Reset while nxt holds a pending sample
        do_reset(2);
        tdata = 16'h1000; tvalid = 1'b1;
        wait_hs("mid_a");
        tdata = 16'h7000;
        @(negedge aclk);
        tvalid = 1'b0;
        check("mid_nxt_full", tready, 0);
        repeat (5) @(negedge aclk);
        arst = 1'b1;
        @(negedge aclk);
        check("mid_rst_code", code, 1);
        arst = 1'b0;
        tdata = 16'hC000; tvalid = 1'b1;
        @(negedge aclk);
        check("mid_nxt_discard", tready, 1);
        wait_hs("mid_c");
        repeat (48) @(negedge aclk);
        check("mid_underrun", und, 0);

        tvalid = 1'b0;
        @(negedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
